// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter (mem_arbiter).
// Holds the FSM state encoding, the requester port ids and the default RAM depth.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StCapture = 2'd2,
    StResp    = 2'd3
  } state_e;

  localparam logic PortFetch = 1'b0;
  localparam logic PortData  = 1'b1;

  localparam int unsigned DefaultDepth = 256;

  // Word index must fall below depth; the two byte-offset bits are ignored.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    logic [31:0] word_idx;
    word_idx = {2'b00, addr[31:2]};
    return word_idx < depth;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection for mem_arbiter: request valids plus last-served port -> one-hot grant.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise port 1 (data) has fixed priority.
module mem_arb_grant
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_port,
  output logic [1:0] grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      // Contention: favour whichever port was not served last.
      grant = (last_port == PortData) ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end
`else
  logic unused_last_port;
  assign unused_last_port = last_port;

  always_comb begin
    grant = 2'b00;
    if (valid[1]) begin
      grant = 2'b10;
    end else if (valid[0]) begin
      grant = 2'b01;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch = port 0, data = port 1) in front of a single-port 1-cycle RAM.
// One transaction in flight; out-of-range addresses answer with err and skip the RAM.
// Arbitration policy set by MEM_ARB_ROUND_ROBIN_EN (see mem_arb_grant).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  input  logic        p0_req_we,
  output logic        p0_rsp_valid,
  input  logic        p0_rsp_ready,
  output logic [31:0] p0_rsp_rdata,
  output logic        p0_rsp_err,

  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  input  logic        p1_req_we,
  output logic        p1_rsp_valid,
  input  logic        p1_rsp_ready,
  output logic [31:0] p1_rsp_rdata,
  output logic        p1_rsp_err,

  output logic [31:0] ram_address,
  output logic [31:0] ram_data_in,
  output logic        ram_write_enable,
  input  logic [31:0] ram_data_out,

  output logic        busy
);

  state_e      state_q;
  logic        port_q;
  logic        last_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [1:0]  grant;
  logic        req_fire;
  logic        rsp_fire;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_we;

  mem_arb_grant u_grant (
    .valid     ({p1_req_valid, p0_req_valid}),
    .last_port (last_q),
    .grant     (grant)
  );

  assign p0_req_ready = (state_q == StIdle) && grant[0];
  assign p1_req_ready = (state_q == StIdle) && grant[1];
  assign req_fire     = p0_req_ready || p1_req_ready;

  assign sel_addr  = grant[1] ? p1_req_addr  : p0_req_addr;
  assign sel_wdata = grant[1] ? p1_req_wdata : p0_req_wdata;
  assign sel_we    = grant[1] ? p1_req_we    : p0_req_we;

  assign rsp_fire = (state_q == StResp) &&
                    ((port_q == PortData) ? p1_rsp_ready : p0_rsp_ready);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      port_q  <= PortFetch;
      last_q  <= PortFetch;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_fire) begin
            port_q  <= grant[1];
            last_q  <= grant[1];
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            we_q    <= sel_we;
            rdata_q <= '0;
            if (addr_in_range(sel_addr, DEPTH)) begin
              err_q   <= 1'b0;
              state_q <= StIssue;
            end else begin
              err_q   <= 1'b1;
              state_q <= StResp;
            end
          end
        end
        StIssue: begin
          state_q <= StCapture;
        end
        StCapture: begin
          rdata_q <= we_q ? '0 : ram_data_out;
          err_q   <= 1'b0;
          state_q <= StResp;
        end
        StResp: begin
          if (rsp_fire) begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign p0_rsp_valid = (state_q == StResp) && (port_q == PortFetch);
  assign p1_rsp_valid = (state_q == StResp) && (port_q == PortData);
  assign p0_rsp_rdata = rdata_q;
  assign p1_rsp_rdata = rdata_q;
  assign p0_rsp_err   = err_q;
  assign p1_rsp_err   = err_q;

  assign ram_address  = addr_q;
  assign ram_data_in  = wdata_q;
  // Reset gates the strobe directly so an in-flight write never lands.
  assign ram_write_enable = reset && (state_q == StIssue) && we_q;

  assign busy = (state_q != StIdle);

endmodule
